sdnf_lut_scan: RTL and testbench
================================

# sdnf_lut_scan

Parametrised, runtime-programmable sum-of-minterms (SDNF) function unit. It holds a 2^N-entry truth table that is loaded serially and evaluates the function on N-bit input vectors with one cycle of latency. It also streams out the minterm indices of the loaded function through a valid/ready port and reports the minterm count. It replaces the fixed per-function combinational SDNF blocks in the lab designs: one instance serves any N-input function without re-synthesis.

## Interface
- `N`, default 5: number of function inputs (1..10). Derived: `TT_W = 2**N` table bits.
- `clk` input, 1: clock; all state changes on the rising edge.
- `rst_n` input, 1: reset, synchronous, active-low.
- `cfg_valid` input, 1: serial table bit offered.
- `cfg_bit` input, 1: table bit. Minterm 0 first, minterm TT_W-1 last.
- `cfg_ready` output, 1: table bit accepted when `cfg_valid && cfg_ready`.
- `eval_valid` input, 1: evaluation request.
- `in` input, N: input vector; `in[N-1]` is the most significant variable.
- `eval_ready` output, 1: request accepted when `eval_valid && eval_ready`.
- `f_valid` output, 1: one-cycle pulse; `f` is the result of the accepted request.
- `f` output, 1: function value; holds until the next result.
- `scan_start` input, 1: level; sampled only in IDLE.
- `scan_busy` output, 1: high in SCAN.
- `m_valid` output, 1: minterm index offered.
- `m_index` output, N: current minterm index.
- `m_ready` input, 1: sink accepts the minterm.
- `scan_done` output, 1: one-cycle pulse at the end of a scan.
- `m_count` output, N+1: number of minterms found by the last completed scan.

## Operation
- Reset (`rst_n`=0 at an edge): state IDLE, table all-zero, load counter 0, `f`=0, `f_valid`=0, `scan_done`=0, `m_count`=0, scan index 0. Reset asserted mid-LOAD or mid-SCAN aborts the operation. No partial result is kept.
- FSM states: IDLE, LOAD, SCAN.
- IDLE:
  - `cfg_ready`=1, `eval_ready`=1.
  - If `cfg_valid`: accept the bit and go to LOAD (this bit counts as bit 1).
  - Else if `scan_start`: go to SCAN; scan index and running count are cleared.
  - `cfg_valid` has priority; `scan_start` in that cycle is ignored.
- LOAD:
  - `cfg_ready`=1, `eval_ready`=0.
  - Each accepted bit shifts the table right, with the new bit entering at MSB.
  - After TT_W accepted bits: table[k] = k-th bit sent (0-based), then go to IDLE.
  - Gaps in `cfg_valid` are allowed.
- SCAN:
  - `cfg_ready`=0, `eval_ready`=0, `scan_busy`=1.
  - `m_index` = scan index; `m_valid` = table[index] (combinational from state).
  - If table[index]=0: advance the index after 1 cycle.
  - If table[index]=1: hold until `m_ready`, then advance and increment the running count.
  - After index TT_W-1 advances: go to IDLE, `m_count` <= running count, `scan_done` pulses. The index does not wrap within a scan.
- Evaluation:
  - On acceptance, the next cycle has `f_valid`=1 and `f` = table[`in`].
  - An evaluation accepted in the same IDLE cycle as the first cfg bit, or as `scan_start`, uses the table as it was before that edge.
- `m_count` width N+1 holds TT_W (all-ones table). It stays stable until the next scan completes.

## Timing
- Eval latency: 1 cycle. Throughput is 1 per cycle in IDLE.
- Load: TT_W accepted bits. Last bit accepted at edge T gives IDLE and the new table usable from cycle T+1.
- Scan with `m_ready` held at 1, start sampled at edge T:
  - Index k is presented in cycle T+1+k.
  - `scan_done`=1 and IDLE in cycle T+TT_W+1.
  - Total duration is TT_W cycles plus one extra cycle per cycle of `m_ready`=0 while `m_valid`=1.
- `m_index` and `m_valid` are stable while `m_valid && !m_ready`.

## Test plan
- Reset then eval: all-zero table, `in`=5'h1F -> `f_valid` pulse next cycle, `f`=0. Also check `m_count`=0 and `cfg_ready`=1 after reset.
- Load 0xFFDD6AC4 (N=5, 32 bits, minterm 0 first) with random `cfg_valid` gaps:
  - `in`=2 -> `f`=1; `in`=0 -> `f`=0; `in`=16 -> `f`=1; `in`=17 -> `f`=0; `in`=31 -> `f`=1.
  - `eval_ready`=0 throughout LOAD.
- Scan of the same table, `m_ready`=1:
  - Indices 2,6,7,9,11,13,14,16,18,19,20,22,23,24..31 in order.
  - `scan_done` exactly 33 cycles after the start edge; `m_count`=21.
- Same scan with `m_ready` toggled randomly:
  - Identical index sequence; no index dropped or duplicated; `m_index` is stable while stalled.
  - `m_count`=21.
- Simultaneous events in IDLE:
  - `cfg_valid`+`scan_start`: LOAD entered, scan never starts.
  - `eval_valid`+first cfg bit: `f` uses the old table.
  - All-ones table scan: `m_count`=32.
- `rst_n`=0 mid-LOAD (bit 10) and mid-SCAN (index 12):
  - Next cycle IDLE with table 0, `m_valid`=0, no `scan_done`, `m_count`=0.

Source files
------------

// File: rtl/sdnf_lut_scan.sv
`default_nettype none
// ============================================================================
//  Module   : sdnf_lut_scan
//  Purpose  : Runtime-programmable sum-of-minterms function unit. Holds a
//             2**N-bit truth table that is loaded serially (minterm 0 first).
//             It evaluates the function with one cycle of latency, and it
//             streams the indices of the set minterms out through a
//             valid/ready port, reporting the minterm count at the end.
//  Ports    : clk, rst_n (sync, active-low)
//             cfg_valid/cfg_bit/cfg_ready   serial table load
//             eval_valid/in/eval_ready      evaluation request
//             f_valid/f                     evaluation result
//             scan_start/scan_busy          scan control
//             m_valid/m_index/m_ready       minterm index stream
//             scan_done/m_count             scan completion and count
//  Revision : 1.0  initial release
// ============================================================================
module sdnf_lut_scan #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_valid,
    input  logic         cfg_bit,
    output logic         cfg_ready,
    input  logic         eval_valid,
    input  logic [N-1:0] in,
    output logic         eval_ready,
    output logic         f_valid,
    output logic         f,
    input  logic         scan_start,
    output logic         scan_busy,
    output logic         m_valid,
    output logic [N-1:0] m_index,
    input  logic         m_ready,
    output logic         scan_done,
    output logic [N:0]   m_count
);

    localparam int TT_W = 2**N;
    localparam logic [N:0]   c_load_last = (N+1)'(TT_W - 1);
    localparam logic [N-1:0] c_idx_last  = N'(TT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SCAN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [TT_W-1:0] r_table;
    logic [N:0]      r_load_cnt;
    logic [N-1:0]    r_idx;
    logic [N:0]      r_run_cnt;
    logic [N:0]      r_m_count;
    logic            r_f;
    logic            r_f_valid;
    logic            r_scan_done;

    logic            w_cfg_acc;
    logic            w_eval_acc;
    logic            w_scan_go;
    logic            w_scan_adv;
    logic            w_cur_bit;
    logic [N:0]      w_run_inc;

    assign w_cur_bit = r_table[r_idx];
    assign w_run_inc = r_run_cnt + {{N{1'b0}}, w_cur_bit};

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        cfg_ready   = 1'b0;
        eval_ready  = 1'b0;
        scan_busy   = 1'b0;
        m_valid     = 1'b0;
        w_scan_go   = 1'b0;
        w_scan_adv  = 1'b0;
        case (r_state)
            S_IDLE: begin
                cfg_ready  = 1'b1;
                eval_ready = 1'b1;
                // A cfg bit wins over scan_start in the same cycle
                if (cfg_valid) begin
                    w_state_nxt = S_LOAD;
                end else if (scan_start) begin
                    w_scan_go   = 1'b1;
                    w_state_nxt = S_SCAN;
                end
            end
            S_LOAD: begin
                cfg_ready = 1'b1;
                if (cfg_valid && (r_load_cnt == c_load_last)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SCAN: begin
                scan_busy = 1'b1;
                m_valid   = w_cur_bit;
                // Zero entries are skipped in one cycle; set entries wait for the sink
                w_scan_adv = !w_cur_bit || m_ready;
                if (w_scan_adv && (r_idx == c_idx_last)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_cfg_acc  = cfg_valid && cfg_ready;
    assign w_eval_acc = eval_valid && eval_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_table     <= '0;
            r_load_cnt  <= '0;
            r_idx       <= '0;
            r_run_cnt   <= '0;
            r_m_count   <= '0;
            r_f         <= 1'b0;
            r_f_valid   <= 1'b0;
            r_scan_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_f_valid   <= w_eval_acc;
            r_scan_done <= 1'b0;

            // Reads the table as it was before any shift at this same edge
            if (w_eval_acc) begin
                r_f <= r_table[in];
            end

            // Right shift with new bit at MSB: after TT_W bits, bit k = k-th bit sent
            if (w_cfg_acc) begin
                r_table <= {cfg_bit, r_table[TT_W-1:1]};
                if (r_load_cnt == c_load_last) begin
                    r_load_cnt <= '0;
                end else begin
                    r_load_cnt <= r_load_cnt + {{N{1'b0}}, 1'b1};
                end
            end

            if (w_scan_go) begin
                r_idx     <= '0;
                r_run_cnt <= '0;
            end else if (w_scan_adv) begin
                // The last index rolls over to 0, leaving the index cleared for next time
                r_idx     <= r_idx + {{(N-1){1'b0}}, 1'b1};
                r_run_cnt <= w_run_inc;
                if (r_idx == c_idx_last) begin
                    r_m_count   <= w_run_inc;
                    r_scan_done <= 1'b1;
                end
            end
        end
    end

    assign f_valid   = r_f_valid;
    assign f         = r_f;
    assign m_index   = r_idx;
    assign scan_done = r_scan_done;
    assign m_count   = r_m_count;

endmodule
`default_nettype wire

// File: tb/tb_sdnf_lut_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdnf_lut_scan
//  Purpose  : Directed self-checking bench for sdnf_lut_scan (N=5).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sdnf_lut_scan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_bit;
    logic       cfg_ready;
    logic       eval_valid;
    logic [4:0] in_v;
    logic       eval_ready;
    logic       f_valid;
    logic       f;
    logic       scan_start;
    logic       scan_busy;
    logic       m_valid;
    logic [4:0] m_index;
    logic       m_ready;
    logic       scan_done;
    logic [5:0] m_count;

    int n_vec = 0;
    int n_err = 0;
    int exp_idx [32];
    int c_a_idx [21] = '{2, 6, 7, 9, 11, 13, 14, 16, 18, 19, 20, 22, 23,
                         24, 25, 26, 27, 28, 29, 30, 31};
    localparam logic [31:0] c_tbl_a = 32'hFFDD6AC4;

    sdnf_lut_scan #(.N(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_bit    (cfg_bit),
        .cfg_ready  (cfg_ready),
        .eval_valid (eval_valid),
        .in         (in_v),
        .eval_ready (eval_ready),
        .f_valid    (f_valid),
        .f          (f),
        .scan_start (scan_start),
        .scan_busy  (scan_busy),
        .m_valid    (m_valid),
        .m_index    (m_index),
        .m_ready    (m_ready),
        .scan_done  (scan_done),
        .m_count    (m_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic do_eval(input string tag, input logic [4:0] v, input logic exp);
        eval_valid = 1'b1;
        in_v       = v;
        chk({tag, "_ready"}, eval_ready, 1);
        tick();
        eval_valid = 1'b0;
        chk({tag, "_fvalid"}, f_valid, 1);
        chk(tag, f, exp);
    endtask

    task automatic load_tbl(input logic [31:0] v, input bit gaps);
        bit er_bad;
        er_bad = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    cfg_valid = 1'b0;
                    if (k > 0 && eval_ready) er_bad = 1'b1;
                    tick();
                end
            end
            cfg_valid = 1'b1;
            cfg_bit   = v[k];
            if (k > 0 && eval_ready) er_bad = 1'b1;
            tick();
        end
        cfg_valid = 1'b0;
        chk("load_eval_ready_low", er_bad, 0);
        chk("load_back_idle", eval_ready, 1);
    endtask

    task automatic run_scan(input string tag, input bit rnd, input int exp_n,
                            input int exp_cnt, input int exp_cycles);
        int   got [$];
        int   cyc;
        bit   done;
        bit   stall_bad;
        bit   prev_stall;
        logic [4:0] prev_idx;
        got.delete();
        cyc = 0; done = 1'b0; stall_bad = 1'b0; prev_stall = 1'b0; prev_idx = '0;
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        while (!done && cyc < 400) begin
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall && m_index !== prev_idx) stall_bad = 1'b1;
            if (m_valid && m_ready) got.push_back(int'(m_index));
            prev_stall = m_valid && !m_ready;
            prev_idx   = m_index;
            tick();
            cyc++;
            if (scan_done) done = 1'b1;
        end
        m_ready = 1'b0;
        chk({tag, "_done"}, done, 1);
        if (exp_cycles > 0) chk({tag, "_cycles"}, cyc + 1, exp_cycles);
        chk({tag, "_len"}, got.size(), exp_n);
        for (int i = 0; i < exp_n; i++) begin
            chk($sformatf("%s_idx%0d", tag, i), (i < got.size()) ? got[i] : -1, exp_idx[i]);
        end
        chk({tag, "_stable"}, stall_bad, 0);
        chk({tag, "_count"}, m_count, exp_cnt);
        chk({tag, "_idle"}, scan_busy, 0);
    endtask

    initial begin
        bit sb_bad;
        int cnt;
        cfg_valid = 0; cfg_bit = 0; eval_valid = 0; in_v = '0;
        scan_start = 0; m_ready = 0; rst_n = 0;

        // Reset state
        do_reset();
        chk("rst_m_count", m_count, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_f_valid", f_valid, 0);
        chk("rst_scan_done", scan_done, 0);
        chk("rst_scan_busy", scan_busy, 0);
        chk("rst_m_valid", m_valid, 0);
        do_eval("rst_eval31", 5'h1F, 1'b0);
        tick();
        chk("rst_fvalid_pulse", f_valid, 0);

        // Load table A with gaps and evaluate
        load_tbl(c_tbl_a, 1'b1);
        do_eval("a_in2", 5'd2, 1'b1);
        do_eval("a_in0", 5'd0, 1'b0);
        do_eval("a_in16", 5'd16, 1'b1);
        do_eval("a_in17", 5'd17, 1'b0);
        do_eval("a_in31", 5'd31, 1'b1);

        // Scans of table A
        for (int i = 0; i < 21; i++) exp_idx[i] = c_a_idx[i];
        run_scan("scanA", 1'b0, 21, 21, 33);
        run_scan("scanA_rnd", 1'b1, 21, 21, 0);

        // cfg_valid + scan_start + eval in the same IDLE cycle
        cfg_valid = 1'b1; cfg_bit = 1'b1; scan_start = 1'b1;
        eval_valid = 1'b1; in_v = 5'd1;
        tick();
        eval_valid = 1'b0;
        chk("sim_f_old_table", f, 0);
        chk("sim_fvalid", f_valid, 1);
        chk("sim_no_scan", scan_busy, 0);
        chk("sim_in_load", eval_ready, 0);
        sb_bad = 1'b0;
        for (int k = 1; k < 32; k++) begin
            cfg_valid  = 1'b1;
            cfg_bit    = 1'b1;
            scan_start = (k < 31);
            if (scan_busy) sb_bad = 1'b1;
            tick();
        end
        cfg_valid = 1'b0; scan_start = 1'b0;
        chk("sim_scan_never", sb_bad, 0);
        do_eval("ones_in0", 5'd0, 1'b1);

        // All-ones scan
        for (int i = 0; i < 32; i++) exp_idx[i] = i;
        run_scan("scan1", 1'b0, 32, 32, 33);

        // Reset mid-SCAN at index 12
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        m_ready = 1'b1;
        cnt = 0;
        while (m_index != 5'd12 && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("rs_reach12", m_index, 12);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_ready = 1'b0;
        chk("rs_m_valid", m_valid, 0);
        chk("rs_busy", scan_busy, 0);
        chk("rs_done", scan_done, 0);
        chk("rs_m_count", m_count, 0);
        chk("rs_cfg_ready", cfg_ready, 1);
        tick();
        chk("rs_done_later", scan_done, 0);
        do_eval("rs_eval31", 5'd31, 1'b0);

        // Reset mid-LOAD at bit 10
        load_tbl(32'hFFFF_FFFF, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cfg_valid = 1'b1; cfg_bit = 1'b1;
            tick();
        end
        cfg_valid = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        cfg_valid = 1'b0;
        chk("rl_eval_ready", eval_ready, 1);
        chk("rl_m_count", m_count, 0);
        chk("rl_m_valid", m_valid, 0);
        do_eval("rl_eval31", 5'd31, 1'b0);
        load_tbl(c_tbl_a, 1'b0);
        do_eval("rl_a_in2", 5'd2, 1'b1);
        do_eval("rl_a_in17", 5'd17, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
